// File: rtl/gl_cmd_issue.sv
// gl_cmd_issue: fetches 32-bit GL command words from instruction memory and
// issues them one at a time to the command decoder, pacing issue with the
// decoder's stall so each command runs to completion before a NOP gap.
// Word format: [31:24] opcode, [23] operand-pointer flag, [22:0] immediate.
module gl_cmd_issue #(
    parameter int          IADDR_W      = 10,
    parameter logic [7:0]  NOP_OPCODE   = 8'hFF,
    parameter logic [7:0]  HALT_OPCODE  = 8'hFE,
    parameter logic [31:0] OPERAND_BASE = 32'h0,
    parameter int          GAP_CYCLES   = 1,
    parameter int          MAX_HOLD     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IADDR_W-1:0] start_pc,
    output logic               imem_en,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               stall,
    output logic [7:0]         opcode,
    output logic [22:0]        imm,
    // 1 = imm is an operand pointer, 0 = imm is a literal
    output logic               imm_type,
    output logic [31:0]        bram_addr_out,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    localparam int HOLD_W = (MAX_HOLD   < 2) ? 2 : $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_reg,      state_next;
    logic [IADDR_W-1:0]  pc_reg,         pc_next;
    logic [31:0]         word_reg,       word_next;
    logic [HOLD_W-1:0]   hold_cnt_reg,   hold_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg,    gap_cnt_next;
    logic                seen_stall_reg, seen_stall_next;
    logic                busy_reg,       busy_next;
    logic                done_reg,       done_next;
    logic                timeout_reg,    timeout_next;

    logic                cmd_active;
    logic                hold_last;

    // In HOLD, the command ends on the first stall-low cycle after a stall,
    // or on the second drive cycle when the decoder never stalled.
    assign hold_last = !stall && (seen_stall_reg || (hold_cnt_reg == HOLD_W'(2)));

    // State and control registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= '0;
            word_reg       <= '0;
            hold_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            seen_stall_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            word_reg       <= word_next;
            hold_cnt_reg   <= hold_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            seen_stall_reg <= seen_stall_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Next-state logic: fetch, wait for read data, issue, hold, gap, repeat.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        word_next       = word_reg;
        hold_cnt_next   = hold_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        seen_stall_next = seen_stall_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        timeout_next    = timeout_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_next      = start_pc;
                    busy_next    = 1'b1;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now; HALT is consumed and never issued.
                word_next = imem_data;
                if (imem_data[31:24] == HALT_OPCODE) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                hold_cnt_next   = HOLD_W'(2);
                seen_stall_next = 1'b0;
                gap_cnt_next    = '0;
                state_next      = S_HOLD;
            end
            S_HOLD: begin
                if (hold_last) begin
                    gap_cnt_next = '0;
                    state_next   = S_GAP;
                end else if (hold_cnt_reg >= HOLD_W'(MAX_HOLD)) begin
                    timeout_next = 1'b1;
                    gap_cnt_next = '0;
                    state_next   = S_GAP;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                    if (stall) begin
                        seen_stall_next = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg >= GAP_W'(GAP_CYCLES - 1)) begin
                    pc_next    = pc_reg + IADDR_W'(1);
                    state_next = S_FETCH;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command fields are driven only while a command is being presented.
    assign cmd_active = (state_reg == S_ISSUE) || (state_reg == S_HOLD);

    assign opcode   = cmd_active ? word_reg[31:24] : NOP_OPCODE;
    assign imm_type = cmd_active & word_reg[23];

    generate
        for (genvar gi = 0; gi < 23; gi++) begin : g_imm
            assign imm[gi] = cmd_active & word_reg[gi];
        end
    endgenerate

    // Operand pointers are word offsets; convert to a byte address.
    assign bram_addr_out = (cmd_active && word_reg[23])
                         ? (OPERAND_BASE + {7'b0, word_reg[22:0], 2'b00})
                         : 32'h0;

    assign imem_en     = (state_reg == S_FETCH);
    assign imem_addr   = pc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_gl_cmd_issue.sv
// Testbench for gl_cmd_issue: table-driven cycle traces for straight-line
// programs plus hand-written sequences for stall, timeout and reset cases.
module tb_gl_cmd_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_to, stall;
    logic [9:0]  start_pc;

    logic        imem_en, imem_en_t;
    logic [9:0]  imem_addr, imem_addr_t;
    logic [31:0] imem_data, imem_data_t;
    logic [7:0]  opcode, opcode_t;
    logic [22:0] imm, imm_t;
    logic        imm_type, imm_type_t;
    logic [31:0] bram_addr_out, bram_addr_out_t;
    logic        busy, busy_t, done, done_t, timeout_err, timeout_err_t;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem [0:1023];

    // Instruction memory model: registered read, data one cycle after enable.
    always @(posedge clk) begin
        if (imem_en)   imem_data   <= mem[imem_addr];
        if (imem_en_t) imem_data_t <= mem[imem_addr_t];
    end

    gl_cmd_issue dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .opcode(opcode), .imm(imm), .imm_type(imm_type),
        .bram_addr_out(bram_addr_out), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    gl_cmd_issue #(.MAX_HOLD(8)) dut_to (
        .clk(clk), .rst(rst), .start(start_to), .start_pc(start_pc),
        .imem_en(imem_en_t), .imem_addr(imem_addr_t), .imem_data(imem_data_t),
        .stall(1'b1), .opcode(opcode_t), .imm(imm_t), .imm_type(imm_type_t),
        .bram_addr_out(bram_addr_out_t), .busy(busy_t), .done(done_t),
        .timeout_err(timeout_err_t)
    );

    typedef struct {
        logic        start;
        logic [9:0]  pc;
        logic [7:0]  op;
        logic [22:0] imm;
        logic        typ;
        logic [31:0] bram;
        logic        en;
        logic [9:0]  addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [9:0] pc, input logic [7:0] op,
                       input logic [22:0] im, input logic ty, input logic [31:0] br,
                       input logic en, input logic [9:0] ad, input logic bu,
                       input logic dn);
        vec_t v;
        v.start = st; v.pc = pc; v.op = op; v.imm = im; v.typ = ty; v.bram = br;
        v.en = en; v.addr = ad; v.busy = bu; v.done = dn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_done(input bit use_to, input string name);
        int n = 0;
        while (!(use_to ? done_t : done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, use_to ? done_t : done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFE00_0000;
        mem[0]  = 32'h0480_0010; mem[1]  = 32'hFE00_0000;  // COLOR, HALT
        mem[4]  = 32'h1200_0000; mem[5]  = 32'h1400_0000;  // LOADID, PUSH
        mem[6]  = 32'hFE00_0000;
        mem[8]  = 32'h0380_0004; mem[9]  = 32'hFE00_0000;  // VERTEX, HALT
        mem[12] = 32'h0480_0010; mem[13] = 32'h1200_0000;  // timeout program
        mem[14] = 32'hFE00_0000;
        mem[16] = 32'h0380_0004; mem[17] = 32'hFE00_0000;  // reset program

        // Program 1: COLOR then HALT; start re-pulsed mid-command (ignored).
        add(1,0,8'hFF,0,0,0,      1,0,1,0);   // FETCH
        add(0,0,8'hFF,0,0,0,      0,0,1,0);   // WAIT
        add(0,0,8'h04,23'h10,1,32'h40, 0,0,1,0); // ISSUE
        add(1,0,8'h04,23'h10,1,32'h40, 0,0,1,0); // HOLD, start ignored
        add(0,0,8'hFF,0,0,0,      0,0,1,0);   // GAP
        add(0,0,8'hFF,0,0,0,      1,1,1,0);   // FETCH pc=1
        add(0,0,8'hFF,0,0,0,      0,0,1,0);   // WAIT (HALT)
        add(0,0,8'hFF,0,0,0,      0,0,0,1);   // DONE
        add(0,0,8'hFF,0,0,0,      0,0,0,1);   // DONE held
        // Program 2: LOADID, PUSH, HALT from start_pc=4.
        add(1,4,8'hFF,0,0,0,      1,4,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,1,0);
        add(0,4,8'h12,0,0,0,      0,0,1,0);
        add(0,4,8'h12,0,0,0,      0,0,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,1,0);
        add(0,4,8'hFF,0,0,0,      1,5,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,1,0);
        add(0,4,8'h14,0,0,0,      0,0,1,0);
        add(0,4,8'h14,0,0,0,      0,0,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,1,0);
        add(0,4,8'hFF,0,0,0,      1,6,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,1,0);
        add(0,4,8'hFF,0,0,0,      0,0,0,1);

        rst = 1; start = 0; start_to = 0; stall = 0; start_pc = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        check("rst.opcode", opcode, 8'hFF);
        check("rst.imem_en", imem_en, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.bram", bram_addr_out, 0);
        check("rst.timeout", timeout_err, 0);
        check("rst.imm_type", imm_type, 0);
        check("rst.opcode_to", opcode_t, 8'hFF);
        $display("reset/idle checked");

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            start_pc = vecs[i].pc;
            @(negedge clk);
            check($sformatf("v%0d.opcode", i), opcode, vecs[i].op);
            check($sformatf("v%0d.imm", i), imm, vecs[i].imm);
            check($sformatf("v%0d.type", i), imm_type, vecs[i].typ);
            check($sformatf("v%0d.bram", i), bram_addr_out, vecs[i].bram);
            check($sformatf("v%0d.imem_en", i), imem_en, vecs[i].en);
            if (vecs[i].en) check($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d.busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d.done", i), done, vecs[i].done);
            $display("vec %0d: start=%0d opcode=%02h imm=%0h type=%0d bram=%0h en=%0d busy=%0d done=%0d",
                     i, vecs[i].start, opcode, imm, imm_type, bram_addr_out, imem_en, busy, done);
        end
        start = 0;

        // VERTEX with decoder stall high for 7 cycles after issue.
        start = 1; start_pc = 8;
        @(negedge clk); start = 0;
        check("vtx.fetch_addr", imem_addr, 8);
        @(negedge clk);
        @(negedge clk);
        check("vtx.issue_op", opcode, 8'h03);
        check("vtx.issue_bram", bram_addr_out, 32'h10);
        for (int j = 2; j <= 8; j++) begin
            @(negedge clk);
            check($sformatf("vtx.hold%0d", j), opcode, 8'h03);
            stall = 1;
        end
        @(negedge clk);
        check("vtx.last", opcode, 8'h03);
        stall = 0;
        @(negedge clk);
        check("vtx.gap", opcode, 8'hFF);
        check("vtx.gap_bram", bram_addr_out, 0);
        @(negedge clk);
        check("vtx.next_en", imem_en, 1);
        check("vtx.next_addr", imem_addr, 9);
        wait_done(0, "vtx.done");
        $display("vertex stall sequence complete");

        // Timeout: stall tied high on dut_to with MAX_HOLD=8.
        start_to = 1; start_pc = 12;
        @(negedge clk); start_to = 0;
        check("to.fetch_addr", imem_addr_t, 12);
        @(negedge clk);
        @(negedge clk);
        check("to.issue_op", opcode_t, 8'h04);
        for (int j = 2; j <= 8; j++) begin
            @(negedge clk);
            check($sformatf("to.hold%0d_op", j), opcode_t, 8'h04);
            check($sformatf("to.hold%0d_err", j), timeout_err_t, 0);
        end
        @(negedge clk);
        check("to.gap_op", opcode_t, 8'hFF);
        check("to.err_set", timeout_err_t, 1);
        @(negedge clk);
        check("to.next_addr", imem_addr_t, 13);
        wait_done(1, "to.done");
        check("to.err_sticky", timeout_err_t, 1);
        check("to.busy_clear", busy_t, 0);
        start_to = 1; start_pc = 14;
        @(negedge clk); start_to = 0;
        check("to.err_cleared", timeout_err_t, 0);
        check("to.restart_busy", busy_t, 1);
        wait_done(1, "to.done2");
        $display("timeout sequence complete");

        // Reset while a stalled command is held, then clean restart.
        start = 1; start_pc = 16;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        stall = 1;
        @(negedge clk);
        check("rh.hold2", opcode, 8'h03);
        @(negedge clk);
        check("rh.hold3", opcode, 8'h03);
        rst = 1; stall = 0;
        @(negedge clk);
        rst = 0;
        check("rh.opcode", opcode, 8'hFF);
        check("rh.busy", busy, 0);
        check("rh.imem_en", imem_en, 0);
        check("rh.bram", bram_addr_out, 0);
        @(negedge clk);
        @(negedge clk);
        start = 1; start_pc = 16;
        @(negedge clk); start = 0;
        check("rh.re_en", imem_en, 1);
        check("rh.re_addr", imem_addr, 16);
        check("rh.re_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        check("rh.issue", opcode, 8'h03);
        @(negedge clk);
        check("rh.hold", opcode, 8'h03);
        @(negedge clk);
        check("rh.gap", opcode, 8'hFF);
        wait_done(0, "rh.done");
        $display("reset-in-hold sequence complete");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
